pingpong_buf: RTL

//   Two-entry ping-pong buffer that sits directly upstream of muxnx2.

---
 rtl/pingpong_buf_pkg.sv | 26 ++
 rtl/regn_en.sv | 32 +++
 rtl/pingpong_buf.sv | 117 +++++++++++
 3 files changed

// File: rtl/pingpong_buf_pkg.sv
// ============================================================================
// pingpong_buf_pkg
// Occupancy encodings and state type shared by the ping-pong buffer files.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pingpong_buf_pkg;

  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
  localparam logic [CNT_W-1:0] CNT_FULL  = 2'd2;

  // The occupancy count doubles as the controller state, so the state
  // encoding is exactly the count value presented on the count port.
  typedef enum logic [CNT_W-1:0] {
    ST_EMPTY = CNT_EMPTY,
    ST_ONE   = CNT_ONE,
    ST_FULL  = CNT_FULL
  } cnt_state_e;

endpackage

`default_nettype wire

// File: rtl/regn_en.sv
// ============================================================================
// regn_en
// M-bit register with load enable and asynchronous active-high reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regn_en #(
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [M-1:0] i_d,
  output logic [M-1:0] o_q
);

  logic [M-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/pingpong_buf.sv
// ============================================================================
// pingpong_buf
// Two-entry ping-pong buffer feeding both banks and a read select to muxnx2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pingpong_buf
  import pingpong_buf_pkg::*;
#(
  parameter int M = 16
) (
  input  logic             pingpong_buf_port_clk,
  input  logic             pingpong_buf_port_rst,
  input  logic [M-1:0]     pingpong_buf_port_in_data,
  input  logic             pingpong_buf_port_in_valid,
  output logic             pingpong_buf_port_in_ready,
  output logic [M-1:0]     pingpong_buf_port_I0,
  output logic [M-1:0]     pingpong_buf_port_I1,
  output logic             pingpong_buf_port_sel,
  output logic             pingpong_buf_port_out_valid,
  input  logic             pingpong_buf_port_out_ready,
  output logic [CNT_W-1:0] pingpong_buf_port_count
);

  logic clk;
  logic rst;

  cnt_state_e r_state;
  cnt_state_e w_state_nxt;
  logic       r_wp;
  logic       r_rp;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_push;
  logic       w_pop;
  logic [M-1:0] w_bank0;
  logic [M-1:0] w_bank1;

  assign clk = pingpong_buf_port_clk;
  assign rst = pingpong_buf_port_rst;

  // Handshake qualifiers come straight from the state register, which keeps
  // every output free of combinational paths from the inputs.
  assign w_in_ready  = (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = pingpong_buf_port_in_valid  & w_in_ready;
  assign w_pop       = pingpong_buf_port_out_ready & w_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wp <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = ST_FULL;
        end else if (w_pop && !w_push) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  regn_en #(.M(M)) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_push & ~r_wp),
    .i_d  (pingpong_buf_port_in_data),
    .o_q  (w_bank0)
  );

  regn_en #(.M(M)) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_push & r_wp),
    .i_d  (pingpong_buf_port_in_data),
    .o_q  (w_bank1)
  );

  assign pingpong_buf_port_I0        = w_bank0;
  assign pingpong_buf_port_I1        = w_bank1;
  assign pingpong_buf_port_sel       = r_rp;
  assign pingpong_buf_port_in_ready  = w_in_ready;
  assign pingpong_buf_port_out_valid = w_out_valid;
  assign pingpong_buf_port_count     = r_state;

endmodule

`default_nettype wire
